// File: rtl/seq_det_scheduler_pkg.sv
// seq_det_scheduler_pkg: state encoding shared by the 0110 detector and its scheduler
package seq_det_scheduler_pkg;
  localparam int STATE_W = 3;
  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 3'd0,
    S_0    = 3'd1,
    S_01   = 3'd2,
    S_011  = 3'd3,
    S_0110 = 3'd4
  } state_t;
endpackage

// File: rtl/seq_det_scheduler_fsm_0110_next.sv
// fsm_0110_next: combinational next state and Moore output of the overlapping 0110 detector
module fsm_0110_next
  import seq_det_scheduler_pkg::*;
(
  input  state_t state,
  input  logic   x,
  output state_t nxt,
  output logic   z_next
);
  // transition table; after a match the trailing 0 seeds the next one
  always_comb begin
    nxt = S_IDLE;
    case (state)
      S_IDLE:  nxt = x ? S_IDLE : S_0;
      S_0:     nxt = x ? S_01 : S_0;
      S_01:    nxt = x ? S_011 : S_0;
      S_011:   nxt = x ? S_IDLE : S_0110;
      S_0110:  nxt = x ? S_01 : S_0;
      default: nxt = S_IDLE;
    endcase
  end
  assign z_next = nxt == S_0110;
endmodule

// File: rtl/seq_det_scheduler.sv
// seq_det_scheduler: round-robin time-sharing of one 0110 detector across NCH serial streams
module seq_det_scheduler
  import seq_det_scheduler_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 clr_cnt,
  input  logic [NCH-1:0]       flush,
  input  logic [NCH-1:0]       req_valid,
  input  logic [NCH-1:0]       req_bit,
  output logic [NCH-1:0]       req_ready,
  output logic                 z_valid,
  output logic [$clog2(NCH)-1:0] z_chan,
  output logic                 z,
  output logic [NCH*CNT_W-1:0] match_cnt
);
  localparam int CW = $clog2(NCH);
  state_t           ctx [NCH];
  logic [CNT_W-1:0] cnt [NCH];
  logic [CW-1:0]    rr_ptr, g, idx;
  logic             found, z_next;
  logic [NCH-1:0]   elig;
  state_t           nxt;
  assign elig = req_valid & ~flush & {NCH{en & reset}};
  // pick the first eligible channel at or after rr_ptr, wrapping past NCH-1
  always_comb begin
    found = 1'b0;
    g     = '0;
    idx   = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = CW'((int'(rr_ptr) + k) % NCH);
      if (!found && elig[idx]) begin
        found = 1'b1;
        g     = idx;
      end
    end
  end
  assign req_ready = found ? NCH'(1) << g : '0;
  fsm_0110_next u_fsm (
    .state  (ctx[g]),
    .x      (req_bit[g]),
    .nxt    (nxt),
    .z_next (z_next)
  );
  // contexts, counters, pointer and result registers advance only for the granted channel
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        ctx[i] <= S_IDLE;
        cnt[i] <= '0;
      end
      rr_ptr  <= '0;
      z_valid <= 1'b0;
      z_chan  <= '0;
      z       <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (flush[i]) ctx[i] <= S_IDLE;
        else if (found && g == CW'(i)) ctx[i] <= nxt;
        if (clr_cnt) cnt[i] <= '0;
        else if (found && g == CW'(i) && z_next && cnt[i] != '1) cnt[i] <= cnt[i] + 1'b1;
      end
      z_valid <= found;
      if (found) begin
        rr_ptr <= (g == CW'(NCH - 1)) ? '0 : g + 1'b1;
        z_chan <= g;
        z      <= z_next;
      end
    end
  end
  for (genvar n = 0; n < NCH; n++) begin : g_cnt
    assign match_cnt[n*CNT_W +: CNT_W] = cnt[n];
  end
endmodule
